// File: rtl/remap_pkg.sv
// Shared types for the remap pipeline: rule opcodes, config entry, signature fold.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package remap_pkg;

    // Entry fields are sized for the largest supported input width (256).
    // Narrower instances zero-extend their selects into them.
    localparam int MAX_W     = 256;
    localparam int MAX_SEL_W = 8;

    typedef enum logic [1:0] {
        OP_CONST = 2'b00,
        OP_PASS  = 2'b01,
        OP_AND   = 2'b10,
        OP_XOR   = 2'b11
    } op_t;

    typedef struct packed {
        op_t                  op;
        logic                 inv;
        logic [MAX_SEL_W-1:0] src_a;
        logic [MAX_SEL_W-1:0] src_b;
    } cfg_entry_t;

    // XOR of the low out_w bits of data, split into sig_w-bit chunks from
    // the LSB up; the final chunk is implicitly zero-padded. The result sits
    // in the low sig_w bits, everything above is zero.
    function automatic logic [MAX_W-1:0] fold(input logic [MAX_W-1:0] data,
                                              input int out_w,
                                              input int sig_w);
        logic [MAX_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < out_w) begin
                acc[MAX_SEL_W'(i % sig_w)] ^= data[MAX_SEL_W'(i)];
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/remap_cell.sv
// Evaluates one output bit from the input word and its config entry.
// Latency: combinational.
// Backpressure: none (pure function of inputs).
// Ports: in_data (input word), entry (rule), result (output bit).
module remap_cell
    import remap_pkg::*;
#(
    parameter int IN_W = 20
) (
    input  logic [IN_W-1:0] in_data,
    input  cfg_entry_t      entry,
    output logic            result
);

    // Zero-padding to the full select range makes any index >= IN_W read 0
    // without an explicit range compare.
    logic [MAX_W-1:0] in_ext;
    logic             a;
    logic             b;

    always_comb begin
        in_ext             = '0;
        in_ext[IN_W-1:0]   = in_data;
        a                  = in_ext[entry.src_a];
        b                  = in_ext[entry.src_b];
        case (entry.op)
            OP_CONST: result = entry.inv;
            OP_PASS:  result = a ^ entry.inv;
            OP_AND:   result = (a & b) ^ entry.inv;
            default:  result = a ^ b ^ entry.inv;
        endcase
    end

endmodule

// File: rtl/remap_pipe.sv
// Programmable bit remap (CONST/PASS/AND/XOR per output bit) with running signature.
// Latency: 2 registers (S1 input word, S2 evaluated result = out_data).
// Backpressure: valid/ready; holds up to 2 words, out_* stable while stalled.
// Ports: clk/rst (sync, active-high); cfg_we/cfg_addr/cfg_data write one rule,
//        cfg_err sticky bad-address flag; in_valid/in_ready/in_data input stream;
//        out_valid/out_ready/out_data output stream; out_sig signature.
module remap_pipe
    import remap_pkg::*;
#(
    parameter  int IN_W  = 20,
    parameter  int OUT_W = 40,
    parameter  int SIG_W = 16,
    localparam int SEL_W = $clog2(IN_W),
    localparam int ADR_W = (OUT_W > 1) ? $clog2(OUT_W) : 1,
    localparam int CFG_W = 3 + 2 * SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [ADR_W-1:0] cfg_addr,
    input  logic [CFG_W-1:0] cfg_data,
    output logic             cfg_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [SIG_W-1:0] out_sig
);

    logic             s1_valid;
    logic [IN_W-1:0]  s1_data;
    logic             s2_valid;
    logic             s2_adv;
    logic             s1_adv;
    logic             in_acc;
    logic             out_hs;
    logic             addr_ok;
    cfg_entry_t       wr_entry;
    logic [OUT_W-1:0] eval_res;
    logic [MAX_W-1:0] data_ext;
    logic [MAX_W-1:0] fold_full;
    logic [SIG_W-1:0] sig_rot;
    logic             unused_fold;

    assign s2_adv   = !s2_valid | out_ready;
    assign s1_adv   = s2_adv & s1_valid;
    assign in_ready = !rst & (!s1_valid | s2_adv);
    assign in_acc   = in_valid & in_ready;
    assign out_hs   = s2_valid & out_ready;
    assign out_valid = s2_valid;
    assign addr_ok  = (int'(cfg_addr) < OUT_W);

    // cfg_data layout: {op[1:0], inv, srcA, srcB}
    always_comb begin
        wr_entry                   = '0;
        wr_entry.op                = op_t'(cfg_data[CFG_W-1 -: 2]);
        wr_entry.inv               = cfg_data[2*SEL_W];
        wr_entry.src_a[SEL_W-1:0]  = cfg_data[2*SEL_W-1 -: SEL_W];
        wr_entry.src_b[SEL_W-1:0]  = cfg_data[SEL_W-1:0];
    end

    // One table entry and one evaluator per output bit. The entry register
    // updates on the same edge that S2 samples the evaluator, so a word
    // evaluated in the write cycle still sees the old rule.
    for (genvar g = 0; g < OUT_W; g++) begin : g_bit
        localparam cfg_entry_t RST_ENTRY = '{
            op:    OP_PASS,
            inv:   1'b0,
            src_a: MAX_SEL_W'(g % IN_W),
            src_b: '0
        };

        cfg_entry_t entry_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                entry_q <= RST_ENTRY;
            end else if (cfg_we && cfg_addr == ADR_W'(g)) begin
                entry_q <= wr_entry;
            end
        end

        remap_cell #(
            .IN_W (IN_W)
        ) u_cell (
            .in_data (s1_data),
            .entry   (entry_q),
            .result  (eval_res[g])
        );
    end

    // Signature update terms. The shift pair is a rotate-left-by-one that
    // degenerates correctly to identity when SIG_W is 1.
    always_comb begin
        data_ext             = '0;
        data_ext[OUT_W-1:0]  = out_data;
        fold_full            = fold(data_ext, OUT_W, SIG_W);
        sig_rot              = (out_sig << 1) | (out_sig >> (SIG_W - 1));
    end

    assign unused_fold = ^fold_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
            out_data <= '0;
            out_sig  <= '0;
            cfg_err  <= 1'b0;
        end else begin
            if (in_acc) begin
                s1_data  <= in_data;
                s1_valid <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s1_adv) begin
                out_data <= eval_res;
            end

            if (out_hs) begin
                out_sig <= sig_rot ^ fold_full[SIG_W-1:0];
            end

            if (cfg_we && !addr_ok) begin
                cfg_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_remap_pipe.sv
module tb_remap_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [5:0]  cfg_addr = '0;
    logic [12:0] cfg_data = '0;
    logic        cfg_err;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [39:0] out_data;
    logic [15:0] out_sig;

    always #5 clk = ~clk;

    remap_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sig   (out_sig)
    );

    int vec_cnt     = 0;
    int miscompares = 0;
    int dlv_cnt     = 0;

    // Behavioural model: rule table, expected-output queue, signature, error flag.
    int          m_op  [40];
    int          m_inv [40];
    int          m_a   [40];
    int          m_b   [40];
    logic [39:0] exp_q   [$];
    logic [39:0] dlv_log [$];
    logic [15:0] m_sig = '0;
    logic        m_err = 1'b0;
    logic        hold_vld = 1'b0;
    logic [39:0] hold_dat = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 40; i++) begin
            m_op[i]  = 1;
            m_inv[i] = 0;
            m_a[i]   = i % 20;
            m_b[i]   = 0;
        end
    endfunction

    function automatic logic bit_of(input logic [19:0] d, input int idx);
        logic [19:0] t;
        if (idx >= 20) return 1'b0;
        t = d >> idx;
        return t[0];
    endfunction

    function automatic logic [39:0] model_eval(input logic [19:0] d);
        logic [39:0] r;
        logic a, b, v;
        r = '0;
        for (int i = 0; i < 40; i++) begin
            a = bit_of(d, m_a[i]);
            b = bit_of(d, m_b[i]);
            case (m_op[i])
                0:       v = 1'b0;
                1:       v = a;
                2:       v = a & b;
                default: v = a ^ b;
            endcase
            r[i] = v ^ (m_inv[i] != 0);
        end
        return r;
    endfunction

    function automatic logic [15:0] model_fold(input logic [39:0] d);
        logic [47:0] p;
        p = {8'h00, d};
        return p[15:0] ^ p[31:16] ^ p[47:32];
    endfunction

    // Compare process: on every falling edge, check outputs against the model
    // and record the handshakes that the next rising edge will perform.
    always @(negedge clk) begin
        chk("out_sig", 64'(out_sig), 64'(m_sig));
        chk("cfg_err", 64'(cfg_err), 64'(m_err));
        if (rst) begin
            chk("in_ready_in_reset", 64'(in_ready), 64'(0));
            exp_q.delete();
            model_reset();
            m_sig    = '0;
            m_err    = 1'b0;
            hold_vld = 1'b0;
        end else begin
            if (out_valid && exp_q.size() == 0) begin
                chk("spurious_out_valid", 64'(out_valid), 64'(0));
            end
            if (hold_vld) begin
                chk("stall_valid", 64'(out_valid), 64'(1));
                chk("stall_data", 64'(out_data), 64'(hold_dat));
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                logic [39:0] e;
                e = exp_q.pop_front();
                chk("out_data", 64'(out_data), 64'(e));
                m_sig = {m_sig[14:0], m_sig[15]} ^ model_fold(e);
                dlv_log.push_back(out_data);
                dlv_cnt++;
            end
            hold_vld = out_valid && !out_ready;
            hold_dat = out_data;
            if (cfg_we) begin
                if (cfg_addr < 6'd40) begin
                    m_op[cfg_addr]  = int'(cfg_data[12:11]);
                    m_inv[cfg_addr] = int'(cfg_data[10]);
                    m_a[cfg_addr]   = int'(cfg_data[9:5]);
                    m_b[cfg_addr]   = int'(cfg_data[4:0]);
                end else begin
                    m_err = 1'b1;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model_eval(in_data));
            end
        end
    end

    task automatic send(input logic [19:0] d);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("send_accepted", 64'(done), 64'(1));
    endtask

    task automatic wait_dlv(input int n);
        for (int t = 0; t < 100 && dlv_cnt < n; t++) begin
            @(posedge clk);
            #1;
        end
        chk("delivered_count", 64'(dlv_cnt), 64'(n));
    endtask

    task automatic cfg_write(input logic [5:0] addr, input logic [12:0] data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int cycles;
        bit take;

        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_sig", 64'(out_sig), 64'(0));
        chk("rst_cfg_err", 64'(cfg_err), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Identity remap and first signature value
        send(20'h00001);
        wait_dlv(1);
        chk("ident_data", 64'(dlv_log[0]), 64'h00_0000_1000_01);
        chk("ident_sig", 64'(out_sig), 64'h0011);

        // Backpressure: only two words fit while the output is stalled
        out_ready = 1'b0;
        acc       = 0;
        in_valid  = 1'b1;
        in_data   = 20'd1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            take = in_ready;
            @(posedge clk);
            #1;
            if (take) begin
                acc++;
                in_data = 20'(acc + 1);
            end
        end
        chk("bp_accepted", 64'(acc), 64'(2));
        @(negedge clk);
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        cycles    = 0;
        while (dlv_cnt < 4 && cycles < 20) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            cycles++;
        end
        in_valid = 1'b0;
        chk("bp_drain_cycles", 64'(cycles), 64'(3));
        chk("bp_word1", 64'(dlv_log[1]), 64'h00_0000_1000_01);
        chk("bp_word2", 64'(dlv_log[2]), 64'h00_0000_2000_02);
        chk("bp_word3", 64'(dlv_log[3]), 64'h00_0000_3000_03);

        // Out-of-range config write is dropped and flagged
        cfg_write(6'd40, {2'b11, 1'b1, 5'd3, 5'd4});
        @(negedge clk);
        chk("cfg_err_set", 64'(cfg_err), 64'(1));
        @(posedge clk);
        #1;
        send(20'h00001);
        wait_dlv(5);
        chk("bad_cfg_no_effect", 64'(dlv_log[4]), 64'h00_0000_1000_01);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("cfg_err_cleared", 64'(cfg_err), 64'(0));
        chk("sig_cleared", 64'(out_sig), 64'(0));
        @(posedge clk);
        #1;

        // XOR rule with inversion on bit 0
        cfg_write(6'd0, {2'b11, 1'b1, 5'd5, 5'd6});
        send(20'h00020);
        wait_dlv(6);
        chk("xor_b6_0", 64'(dlv_log[5]), 64'h00_0002_0000_20);
        send(20'h00060);
        wait_dlv(7);
        chk("xor_b6_1", 64'(dlv_log[6]), 64'h00_0006_0000_61);

        // Config write coincident with an evaluation: old rule, then new rule
        in_valid = 1'b1;
        in_data  = 20'h00020;
        @(posedge clk);
        #1;
        cfg_we   = 1'b1;
        cfg_addr = 6'd0;
        cfg_data = {2'b00, 1'b1, 5'd0, 5'd0};
        @(posedge clk);
        #1;
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        wait_dlv(9);
        chk("cfg_timing_old", 64'(dlv_log[7]), 64'h00_0002_0000_20);
        chk("cfg_timing_new", 64'(dlv_log[8]), 64'h00_0002_0000_21);

        // Reset with two words in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 20'h00003;
        @(posedge clk);
        #1;
        in_data = 20'h00005;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("inflight_valid", 64'(out_valid), 64'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_out_sig", 64'(out_sig), 64'(0));
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_stale", 64'(dlv_cnt), 64'(9));
        send(20'h00020);
        wait_dlv(10);
        chk("midrst_identity", 64'(dlv_log[9]), 64'h00_0002_0000_20);
        chk("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
